// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, op selects and default latencies for the mult/div sequencer.
package muldiv_pkg;
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_RUN       = 3'd2,
        S_WRITEBACK = 3'd3,
        S_DONE      = 3'd4,
        S_EXC       = 3'd5
    } state_t;
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;
    localparam int MULT_CYCLES_DEF = 32;
    localparam int DIV_CYCLES_DEF  = 32;
    localparam int CNT_W_DEF       = 6;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: control handshake between the main FSM and the mult/div sequencer.
// Perf counter signals exist only when MULDIV_SEQ_PERF_EN is defined.
interface muldiv_seq_if;
    logic start, op_div, divisor_zero, abort;
    logic busy, mult_start, div_start, mult_or_div, hi_w, lo_w, done, div0_exc;
`ifdef MULDIV_SEQ_PERF_EN
    logic [15:0] ops_cnt;
    logic [7:0]  exc_cnt;
    modport master (output start, op_div, divisor_zero, abort,
                    input busy, mult_start, div_start, mult_or_div, hi_w, lo_w, done, div0_exc,
                          ops_cnt, exc_cnt);
    modport slave  (input start, op_div, divisor_zero, abort,
                    output busy, mult_start, div_start, mult_or_div, hi_w, lo_w, done, div0_exc,
                           ops_cnt, exc_cnt);
`else
    modport master (output start, op_div, divisor_zero, abort,
                    input busy, mult_start, div_start, mult_or_div, hi_w, lo_w, done, div0_exc);
    modport slave  (input start, op_div, divisor_zero, abort,
                    output busy, mult_start, div_start, mult_or_div, hi_w, lo_w, done, div0_exc);
`endif
endinterface

// File: rtl/muldiv_lat_cnt.sv
// muldiv_lat_cnt: loadable down-counter timing the selected unit's fixed latency.
module muldiv_lat_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             expire_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign value_o  = cnt_q;
    assign expire_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: launches the mult or div unit, times its latency, writes HI/LO and signals done;
// divide-by-zero is trapped before launch. MULDIV_SEQ_PERF_EN adds ops/exception counters.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    muldiv_seq_if.slave bus
);
    state_t           state_q, state_d;
    logic             mod_q, mod_d;
    logic             expire;
    logic [CNT_W-1:0] cnt_val;

    muldiv_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == S_LAUNCH),
        .dec_i      (state_q == S_RUN),
        .load_val_i (mod_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)),
        .value_o    (cnt_val),
        .expire_o   (expire)
    );

    always_comb begin
        state_d = state_q;
        mod_d   = mod_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = (bus.op_div && bus.divisor_zero) ? S_EXC : S_LAUNCH;
                mod_d   = (bus.op_div && bus.divisor_zero) ? mod_q : bus.op_div;
            end
            S_LAUNCH:    state_d = S_RUN;
            S_RUN:       state_d = expire ? S_WRITEBACK : S_RUN;
            S_WRITEBACK: state_d = S_DONE;
            default:     state_d = S_IDLE;
        endcase
        if (bus.abort) begin
            state_d = S_IDLE;
            mod_d   = mod_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_IDLE;
            mod_q   <= OP_MULT;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
        end

    // write enables and the exception pulse are gated so a same-cycle abort cannot leak through
    assign bus.busy        = state_q != S_IDLE;
    assign bus.mult_start  = state_q == S_LAUNCH && mod_q == OP_MULT;
    assign bus.div_start   = state_q == S_LAUNCH && mod_q == OP_DIV;
    assign bus.mult_or_div = mod_q;
    assign bus.hi_w        = state_q == S_WRITEBACK && !bus.abort;
    assign bus.lo_w        = bus.hi_w;
    assign bus.done        = state_q == S_DONE;
    assign bus.div0_exc    = state_q == S_EXC && !bus.abort;

    a_run_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        state_q == S_RUN |-> cnt_val != '0);

`ifdef MULDIV_SEQ_PERF_EN
    logic [15:0] ops_q, ops_d;
    logic [7:0]  exc_q, exc_d;
    always_comb begin
        ops_d = (bus.done && ops_q != '1) ? ops_q + 16'd1 : ops_q;
        exc_d = (bus.div0_exc && exc_q != '1) ? exc_q + 8'd1 : exc_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ops_q <= '0;
            exc_q <= '0;
        end else begin
            ops_q <= ops_d;
            exc_q <= exc_d;
        end
    assign bus.ops_cnt = ops_q;
    assign bus.exc_cnt = exc_q;
`endif
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized self-checking bench; expected outputs come from a per-cycle timeline
// derived from the start edge, selected latency and abort cycle.
module tb_muldiv_seq;
    localparam int MULT_N = 32;
    localparam int DIV_N  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic mod_m = 1'b0;
    int ops_m = 0;
    int exc_m = 0;

    muldiv_seq_if bus();

    muldiv_seq #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {bus.busy, bus.mult_start, bus.div_start, bus.mult_or_div,
                bus.hi_w, bus.lo_w, bus.done, bus.div0_exc};
    endfunction

    // Expected {busy, mult_start, div_start, mult_or_div, hi_w, lo_w, done, div0_exc}
    // in cycle k after the start edge; a is the abort cycle (0 = none).
    function automatic logic [7:0] exp_vec(input logic op, input logic dz, input int k,
                                           input int a, input logic mod_prev);
        int n;
        logic alive, wb;
        n = op ? DIV_N : MULT_N;
        alive = (a == 0) || (k <= a);
        if (dz)
            return {k == 1, 1'b0, 1'b0, mod_prev, 1'b0, 1'b0, 1'b0, k == 1 && a != 1};
        wb = alive && k == n + 2 && a != k;
        return {alive && k <= n + 3, alive && k == 1 && !op, alive && k == 1 && op, op,
                wb, wb, alive && k == n + 3, 1'b0};
    endfunction

    task automatic run_op(input string name, input logic op, input logic dz,
                          input int a, input int bs);
        int n, l;
        logic [7:0] e, o;
        n = op ? DIV_N : MULT_N;
        l = dz ? 3 : n + 4;
        @(negedge clk);
        bus.start = 1'b1; bus.op_div = op; bus.divisor_zero = dz;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.op_div = 1'($urandom); bus.divisor_zero = 1'($urandom);
        for (int k = 1; k <= l; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            bus.abort = (k == a);
            bus.start = (k == bs);
            if (k == bs) bus.op_div = 1'($urandom);
            @(negedge clk);
            e = exp_vec(op, dz, k, a, mod_m);
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, k, o, e);
            end
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        if (!dz) mod_m = op;
        if (!dz && a == 0) ops_m = (ops_m < 16'hFFFF) ? ops_m + 1 : ops_m;
        if (dz && a != 1) exc_m = (exc_m < 8'hFF) ? exc_m + 1 : exc_m;
    endtask

    task automatic test_reset();
        logic [7:0] o;
        bus.start = 0; bus.op_div = 0; bus.divisor_zero = 0; bus.abort = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_held: got %b expected 00000000", obs());
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: got %b expected 00000000", obs());
        end
        run_op("pre_reset_div", 1'b1, 1'b0, 0, 0);
        bus.start = 1'b1; bus.op_div = 1'b1; bus.divisor_zero = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_busy: got %b expected 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b expected 00000000", o);
        end
        mod_m = 1'b0; ops_m = 0; exc_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_op("mult", 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_div();
        run_op("div", 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_div0();
        run_op("div0", 1'b1, 1'b1, 0, 0);
    endtask

    task automatic test_abort();
        run_op("abort_run_cnt10", 1'b0, 1'b0, MULT_N - 8, 0);
        run_op("abort_writeback", 1'b1, 1'b0, DIV_N + 2, 0);
        run_op("abort_div0", 1'b1, 1'b1, 1, 0);
        run_op("start_while_busy", 1'b0, 1'b0, 0, 5);
        run_op("start_in_done", 1'b1, 1'b0, 0, DIV_N + 3);
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.op_div = ~mod_m; bus.divisor_zero = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== {3'b000, mod_m, 4'b0000}) begin
            errors++;
            $display("FAIL abort_with_start: got %b expected %b", obs(), {3'b000, mod_m, 4'b0000});
        end
    endtask

    task automatic test_random();
        logic op, dz;
        int n, a, bs;
        for (int i = 0; i < 10; i++) begin
            op = 1'($urandom);
            dz = op && ($urandom_range(0, 2) == 0);
            n  = op ? DIV_N : MULT_N;
            a = 0; bs = 0;
            if (dz) a = ($urandom_range(0, 3) == 0) ? 1 : 0;
            else if ($urandom_range(0, 2) == 0) a = $urandom_range(2, n + 2);
            if (!dz && $urandom_range(0, 1) == 1) bs = $urandom_range(2, (a != 0) ? a : n + 3);
            run_op("random", op, dz, a, bs);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mult", 1'b0, 1'b0, 0, 0);
        run_op("b2b_div0", 1'b1, 1'b1, 0, 0);
        run_op("b2b_div", 1'b1, 1'b0, 0, 0);
        run_op("b2b_mult2", 1'b0, 1'b0, 0, 0);
    endtask

`ifdef MULDIV_SEQ_PERF_EN
    task automatic test_perf();
        checks++;
        if (bus.ops_cnt !== 16'(ops_m)) begin
            errors++;
            $display("FAIL ops_cnt: got %0d expected %0d", bus.ops_cnt, ops_m);
        end
        checks++;
        if (bus.exc_cnt !== 8'(exc_m)) begin
            errors++;
            $display("FAIL exc_cnt: got %0d expected %0d", bus.exc_cnt, exc_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_abort();
        test_random();
        test_back_to_back();
`ifdef MULDIV_SEQ_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencer for the multicycle multiply and divide units that feed the HI/LO registers.
- The main control FSM issues one start with an op select. This block then:
  - pulses the selected unit's start,
  - counts its fixed latency,
  - steers the mult/div result mux,
  - writes HI and LO,
  - returns a done pulse.
- Divide-by-zero is intercepted before launch and reported as an exception, so HI/LO are never corrupted.

Parameters:
- MULT_CYCLES, 32, cycles the mult unit needs after its start pulse before its outputs are valid (range 1..63).
- DIV_CYCLES, 32, same for the div unit (range 1..63).
- CNT_W, 6, latency counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- start  in  1  request from the main control FSM; sampled only in IDLE
- op_div  in  1  0 = MULT, 1 = DIV; sampled with start
- divisor_zero  in  1  1 when the B operand equals 0; sampled with start
- abort  in  1  flush from exception handling; any state goes to IDLE
- busy  out  1  1 in every state except IDLE
- mult_start  out  1  one-cycle start pulse to the mult unit
- div_start  out  1  one-cycle start pulse to the div unit
- mult_or_div  out  1  HI/LO input mux select (0 = mult, 1 = div)
- hi_w  out  1  HI register write enable
- lo_w  out  1  LO register write enable
- done  out  1  one-cycle completion pulse
- div0_exc  out  1  one-cycle divide-by-zero exception pulse

Behaviour:
- Reset values:
  - state = IDLE, counter = 0, mult_or_div = 0.
  - All pulse outputs and busy are 0.
- States: IDLE, LAUNCH, RUN, WRITEBACK, DONE, EXC.
- IDLE:
  - start=1 with op_div=1 and divisor_zero=1 goes to EXC.
  - Any other start=1 goes to LAUNCH, latching op_div into mult_or_div.
  - start=0 stays in IDLE.
- EXC: div0_exc=1 for one cycle, then IDLE. No unit start, no hi_w/lo_w, done stays 0.
- LAUNCH:
  - mult_start=1 (MULT) or div_start=1 (DIV) for exactly one cycle.
  - Counter loaded with MULT_CYCLES or DIV_CYCLES; then RUN.
- RUN: counter decrements each cycle; when counter==1, go to WRITEBACK.
- WRITEBACK: hi_w=1 and lo_w=1 for one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: start sampled at edge T gives:
  - LAUNCH at T+1,
  - WRITEBACK at T+1+N+1,
  - done high in cycle T+N+3, where N is the selected latency.
- mult_or_div:
  - Holds its value from acceptance until the next accepted start.
  - Stable throughout WRITEBACK; stays valid after DONE for later HI/LO reads.
- start outside IDLE is ignored. No queuing, no error indication.
- abort:
  - Highest priority; the next state is IDLE from any state.
  - An abort in the same cycle as WRITEBACK still suppresses hi_w/lo_w; the enables are gated combinationally by !abort.
  - An abort during EXC suppresses div0_exc.
  - abort together with start in IDLE: the start is discarded.
- Asynchronous reset mid-operation returns to IDLE immediately; outputs take their reset values asynchronously.
- At most one of mult_start, div_start, hi_w, done, div0_exc is high in any cycle (hi_w and lo_w always move together).

Optional Feature:
- Macro MULDIV_SEQ_PERF_EN.
- When defined:
  - Adds output ops_cnt [15:0]: increments on each done pulse, saturates at 16'hFFFF.
  - Adds output exc_cnt [7:0]: increments on each div0_exc pulse, saturates at 8'hFF.
  - Both counters cleared by reset.
- When undefined: neither port nor either counter exists; all other behaviour is identical.

Decomposition:
- Package muldiv_pkg holds:
  - the state enum (3-bit encoding: IDLE=0, LAUNCH=1, RUN=2, WRITEBACK=3, DONE=4, EXC=5),
  - op constants OP_MULT=0, OP_DIV=1,
  - the default latency constants.
- One sub-module, muldiv_lat_cnt: a loadable down-counter of width CNT_W with load, value and "expire" (value==1) outputs.
- The FSM and output decode stay in muldiv_seq.

Test Plan:
1. Reset low for 3 cycles, then high → busy=0, all pulses 0, mult_or_div=0. Asserting reset low mid-RUN → busy drops to 0 asynchronously.
2. MULT, MULT_CYCLES=32: start=1, op_div=0 for one cycle → mult_start high exactly 1 cycle after start; hi_w/lo_w high 34 cycles after start; done high 35 cycles after start; mult_or_div=0; busy high for 35 cycles.
3. DIV, DIV_CYCLES=32, divisor_zero=0 → div_start pulse; mult_or_div=1 from LAUNCH onward; done 35 cycles after start; div0_exc stays 0.
4. DIV with divisor_zero=1 → div0_exc high exactly 1 cycle after start; no div_start, no hi_w/lo_w, no done; busy high for 1 cycle.
5. Abort during RUN at count 10, and a separate abort coinciding with WRITEBACK → state IDLE next cycle, hi_w/lo_w never asserted, done never asserted. A start issued while busy is ignored (no extra mult_start).
6. With MULDIV_SEQ_PERF_EN: 3 MULTs plus 2 div-by-zero requests → ops_cnt=3, exc_cnt=2. Forcing ops_cnt to 16'hFFFF and completing one more op → ops_cnt stays at 16'hFFFF.
